// File: rtl/ysyx_24100005_lsu.sv
// ysyx_24100005_lsu -- single-outstanding load/store unit between a core
// request port and a simple valid/ready memory port.
//
// Parameters:
//   XLEN    : data/address width, 32 or 64.
//   TIMEOUT : WAIT cycles without mem_rvalid before a timeout response
//             (0 = wait forever).
//
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   req_valid/ready   : core request handshake (ready only while idle)
//   req_we            : 1 = store, 0 = load
//   req_funct3        : RISC-V load/store funct3 (size + unsigned flag)
//   req_addr/wdata    : byte address and store data (LSB-aligned)
//   resp_valid/ready  : response handshake
//   resp_rdata        : extended load data (0 for stores and errors)
//   resp_cause        : 00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
//   mem_valid/ready   : memory command handshake
//   mem_we/addr/wdata/wmask : word-aligned command, lane-shifted data/mask
//   mem_rvalid/rdata  : memory response; mem_rvalid also acknowledges stores
module ysyx_24100005_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [XLEN-1:0]     resp_rdata,
  output logic [1:0]          resp_cause,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wmask,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value at which the next silent WAIT cycle is the TIMEOUT-th one.
  localparam logic [31:0] TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [1:0] CAUSE_OK       = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [OFFW-1:0] off_q;

  // ---------------------------------------------------------------------
  // Request decode (evaluated on the accept cycle only)
  // ---------------------------------------------------------------------
  logic [1:0]      req_size;
  logic [OFFW-1:0] req_off;
  logic            req_illegal;
  logic            req_misaligned;
  logic [3:0]      req_bytes;
  logic [NB-1:0]   ones_nb;
  logic [NB-1:0]   size_mask;
  logic [NB-1:0]   req_wmask;
  logic [XLEN-1:0] req_wdata_sh;

  always_comb begin
    req_size  = req_funct3[1:0];
    req_off   = req_addr[OFFW-1:0];
    req_illegal = (req_funct3 == 3'b111) ||
                  (req_we && req_funct3[2]) ||
                  ((XLEN == 32) && (req_size == 2'b11));
    case (req_size)
      2'b00:   req_misaligned = 1'b0;
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = |req_addr[1:0];
      default: req_misaligned = |req_addr[2:0];
    endcase
    // Byte-enable of the access size at lane 0, then moved to its lane.
    req_bytes    = 4'd1 << req_size;
    ones_nb      = '1;
    size_mask    = ~(ones_nb << req_bytes);
    req_wmask    = size_mask << req_off;
    req_wdata_sh = req_wdata << {req_off, 3'b000};
  end

  // ---------------------------------------------------------------------
  // Load data alignment and extension (uses the latched request)
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] rd_shifted;
  logic [6:0]      rd_bits;
  logic [XLEN-1:0] ones_x;
  logic [XLEN-1:0] rd_mask;
  logic            rd_sign;
  logic [XLEN-1:0] load_val;

  always_comb begin
    rd_shifted = mem_rdata >> {off_q, 3'b000};
    rd_bits    = 7'd8 << f3_q[1:0];
    ones_x     = '1;
    // Shifting by XLEN (full-width access) yields an all-ones mask.
    rd_mask    = ~(ones_x << rd_bits);
    case (f3_q[1:0])
      2'b00:   rd_sign = rd_shifted[7];
      2'b01:   rd_sign = rd_shifted[15];
      2'b10:   rd_sign = rd_shifted[31];
      default: rd_sign = rd_shifted[XLEN-1];
    endcase
    load_val = (rd_shifted & rd_mask) |
               ((!f3_q[2] && rd_sign) ? ~rd_mask : '0);
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_cause <= CAUSE_OK;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            f3_q      <= req_funct3;
            off_q     <= req_off;
            if (req_illegal || req_misaligned) begin
              // Errors skip the memory entirely; illegal outranks misaligned.
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_cause <= req_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
            end else begin
              state     <= S_ISSUE;
              mem_valid <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
              mem_wdata <= req_wdata_sh;
              mem_wmask <= req_we ? req_wmask : '0;
            end
          end else begin
            // Also raises ready on the first cycle after reset release.
            req_ready <= 1'b1;
          end
        end

        S_ISSUE: begin
          if (mem_ready) begin
            state     <= S_WAIT;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= '0;
            cnt       <= '0;
          end
        end

        S_WAIT: begin
          // Data arriving on the timeout cycle takes precedence.
          if (mem_rvalid) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_cause <= CAUSE_OK;
            resp_rdata <= we_q ? '0 : load_val;
          end else if ((TIMEOUT != 0) && (cnt == TLAST[CW-1:0])) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_cause <= CAUSE_TIMEOUT;
            resp_rdata <= '0;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + CW'(1);
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Testbench for ysyx_24100005_lsu: a 32-bit instance with TIMEOUT=4 and a
// 64-bit instance with the default timeout share the stimulus signals; the
// bench selects which one is addressed and compares against a byte-level
// reference model.
module tb_ysyx_24100005_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  bit          use64 = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_ready = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;

  logic        d_req_valid, q_req_valid;

  logic        d_req_ready, d_resp_valid, d_mem_valid, d_mem_we;
  logic [31:0] d_resp_rdata, d_mem_addr, d_mem_wdata;
  logic [1:0]  d_resp_cause;
  logic [3:0]  d_mem_wmask;

  logic        q_req_ready, q_resp_valid, q_mem_valid, q_mem_we;
  logic [63:0] q_resp_rdata, q_mem_addr, q_mem_wdata;
  logic [1:0]  q_resp_cause;
  logic [7:0]  q_mem_wmask;

  logic        o_req_ready, o_resp_valid, o_mem_valid, o_mem_we;
  logic [63:0] o_resp_rdata, o_mem_addr, o_mem_wdata;
  logic [1:0]  o_resp_cause;
  logic [7:0]  o_mem_wmask;

  int n_checks = 0;
  int n_fail   = 0;

  assign d_req_valid = req_valid & ~use64;
  assign q_req_valid = req_valid & use64;

  assign o_req_ready  = use64 ? q_req_ready  : d_req_ready;
  assign o_resp_valid = use64 ? q_resp_valid : d_resp_valid;
  assign o_mem_valid  = use64 ? q_mem_valid  : d_mem_valid;
  assign o_mem_we     = use64 ? q_mem_we     : d_mem_we;
  assign o_resp_rdata = use64 ? q_resp_rdata : {32'b0, d_resp_rdata};
  assign o_mem_addr   = use64 ? q_mem_addr   : {32'b0, d_mem_addr};
  assign o_mem_wdata  = use64 ? q_mem_wdata  : {32'b0, d_mem_wdata};
  assign o_resp_cause = use64 ? q_resp_cause : d_resp_cause;
  assign o_mem_wmask  = use64 ? q_mem_wmask  : {4'b0, d_mem_wmask};

  ysyx_24100005_lsu #(.XLEN(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(d_req_valid), .req_ready(d_req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
    .resp_valid(d_resp_valid), .resp_ready(resp_ready), .resp_rdata(d_resp_rdata),
    .resp_cause(d_resp_cause),
    .mem_valid(d_mem_valid), .mem_ready(mem_ready), .mem_we(d_mem_we),
    .mem_addr(d_mem_addr), .mem_wdata(d_mem_wdata), .mem_wmask(d_mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0])
  );

  ysyx_24100005_lsu #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(q_req_valid), .req_ready(q_req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(q_resp_valid), .resp_ready(resp_ready), .resp_rdata(q_resp_rdata),
    .resp_cause(q_resp_cause),
    .mem_valid(q_mem_valid), .mem_ready(mem_ready), .mem_we(q_mem_we),
    .mem_addr(q_mem_addr), .mem_wdata(q_mem_wdata), .mem_wmask(q_mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Reference model: byte-oriented view of the RISC-V access rules
  // ---------------------------------------------------------------------
  function automatic logic [1:0] m_cause(input bit we, input logic [2:0] f3,
                                         input logic [63:0] addr, input int xlen);
    int nb;
    nb = 1 << f3[1:0];
    if (f3 == 3'b111 || (xlen == 32 && f3[1:0] == 2'b11) || (we && f3[2]))
      return 2'b11;
    if ((addr % nb) != 0)
      return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] addr,
                                         input logic [63:0] rdata, input int xlen);
    int nb, xb, off;
    logic sgn;
    logic [63:0] res;
    nb  = 1 << f3[1:0];
    xb  = xlen / 8;
    off = int'(addr % xb);
    sgn = !f3[2] && rdata[8*(off+nb)-1];
    res = '0;
    for (int i = 0; i < xb; i++) begin
      if (i < nb) res[8*i +: 8] = rdata[8*(off+i) +: 8];
      else        res[8*i +: 8] = {8{sgn}};
    end
    return res;
  endfunction

  function automatic logic [7:0] m_wmask(input bit we, input logic [2:0] f3,
                                         input logic [63:0] addr, input int xlen);
    int nb, off;
    logic [7:0] m;
    nb  = 1 << f3[1:0];
    off = int'(addr % (xlen / 8));
    m   = '0;
    if (we)
      for (int i = 0; i < nb; i++) m[off+i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] wdata, input logic [63:0] addr,
                                          input int xlen);
    int off;
    logic [63:0] v;
    off = int'(addr % (xlen / 8));
    v   = wdata << (8 * off);
    if (xlen == 32) v[63:32] = '0;
    return v;
  endfunction

  // ---------------------------------------------------------------------
  // One complete transaction on the selected instance with inline checks
  // ---------------------------------------------------------------------
  task automatic do_txn(input bit we, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdata,
                        input int rdy_dly, input int rv_dly, input string tag);
    int xlen, waited;
    logic [1:0]  ecause;
    logic [63:0] erd, eaddr, ewd;
    logic [7:0]  em;
    xlen   = use64 ? 64 : 32;
    ecause = m_cause(we, f3, addr, xlen);
    erd    = (ecause != 2'b00 || we) ? 64'd0 : m_load(f3, addr, rdata, xlen);
    eaddr  = addr & ~64'(xlen / 8 - 1);
    ewd    = m_wdata(wdata, addr, xlen);
    em     = m_wmask(we, f3, addr, xlen);

    waited = 0;
    while (!o_req_ready && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    n_checks++;
    if (o_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s req_ready: got %b required 1 within 20 cycles", tag, o_req_ready);
      return;
    end

    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    // Scramble request fields so the DUT must have latched them.
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};

    n_checks++;
    if (o_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s ready_after_accept: got %b required 0", tag, o_req_ready);
    end

    if (ecause != 2'b00) begin
      n_checks++;
      if (o_mem_valid !== 1'b0 || o_resp_valid !== 1'b1 || o_resp_cause !== ecause ||
          o_resp_rdata !== 64'd0) begin
        n_fail++;
        $display("FAIL %s err_resp: got mv=%b rv=%b cause=%b rd=%h required mv=0 rv=1 cause=%b rd=0",
                 tag, o_mem_valid, o_resp_valid, o_resp_cause, o_resp_rdata, ecause);
      end
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        n_checks++;
        if (o_mem_valid !== 1'b1 || o_mem_we !== we || o_mem_addr !== eaddr ||
            o_mem_wdata !== ewd || o_mem_wmask !== em || o_resp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s issue: got v=%b we=%b a=%h d=%h m=%b rv=%b required v=1 we=%b a=%h d=%h m=%b rv=0",
                   tag, o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
                   o_resp_valid, we, eaddr, ewd, em);
        end
        if (i < rdy_dly) begin
          // Stray rvalid during ISSUE must be ignored.
          mem_rvalid = 1'($urandom); mem_rdata = {$urandom, $urandom};
          @(posedge clk); #1;
          mem_rvalid = 1'b0;
        end
      end
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      n_checks++;
      if (o_mem_valid !== 1'b0 || o_resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s wait_entry: got mv=%b rv=%b required 0 0", tag, o_mem_valid, o_resp_valid);
      end
      for (int i = 0; i < rv_dly; i++) begin
        @(posedge clk); #1;
        n_checks++;
        if (o_resp_valid !== 1'b0) begin
          n_fail++; $display("FAIL %s early_resp: got rv=%b required 0", tag, o_resp_valid);
        end
      end
      mem_rvalid = 1'b1; mem_rdata = rdata;
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
      n_checks++;
      if (o_resp_valid !== 1'b1 || o_resp_cause !== 2'b00 || o_resp_rdata !== erd) begin
        n_fail++;
        $display("FAIL %s resp: got rv=%b cause=%b rd=%h required rv=1 cause=00 rd=%h",
                 tag, o_resp_valid, o_resp_cause, o_resp_rdata, erd);
      end
    end

    // One stall cycle: response must hold and no new request may be accepted.
    @(posedge clk); #1;
    n_checks++;
    if (o_resp_valid !== 1'b1 || o_resp_cause !== ecause || o_resp_rdata !== erd ||
        o_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s resp_hold: got rv=%b cause=%b rd=%h rr=%b required rv=1 cause=%b rd=%h rr=0",
               tag, o_resp_valid, o_resp_cause, o_resp_rdata, o_req_ready, ecause, erd);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_checks++;
    if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s resp_done: got rv=%b rr=%b required rv=0 rr=1", tag, o_resp_valid, o_req_ready);
    end
    $display("txn %s xlen=%0d we=%0d f3=%0d addr=%h cause=%b rdata=%h", tag, xlen, we, f3, addr,
             ecause, erd);
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (d_req_ready !== 1'b0 || d_resp_valid !== 1'b0 || d_mem_valid !== 1'b0 ||
        d_mem_we !== 1'b0 || d_mem_wmask !== 4'b0 || d_resp_rdata !== 32'b0 ||
        d_resp_cause !== 2'b0 || q_req_ready !== 1'b0 || q_resp_valid !== 1'b0 ||
        q_mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got rr=%b rv=%b mv=%b we=%b m=%b rd=%h c=%b required all 0",
               d_req_ready, d_resp_valid, d_mem_valid, d_mem_we, d_mem_wmask, d_resp_rdata,
               d_resp_cause);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    n_checks++;
    if (d_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got req_ready=%b required 0", d_req_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (d_req_ready !== 1'b1 || q_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_rise: got %b/%b required 1/1", d_req_ready, q_req_ready);
    end
    $display("txn reset done");
  endtask

  task automatic test_directed();
    use64 = 1'b0;
    do_txn(1'b0, 3'b000, 64'h8000_0003, 64'h0, 64'h8011_2233, 0, 0, "lb_neg");
    do_txn(1'b1, 3'b001, 64'h8000_0002, 64'h0000_ABCD, 64'h0, 0, 0, "sh_hi");
    do_txn(1'b0, 3'b010, 64'h8000_0002, 64'h0, 64'h0, 0, 0, "lw_misaligned");
    do_txn(1'b0, 3'b011, 64'h8000_0000, 64'h0, 64'h0, 0, 0, "ld_on_32");
    do_txn(1'b1, 3'b100, 64'h8000_0001, 64'h0, 64'h0, 0, 0, "store_f3_100");
    do_txn(1'b0, 3'b111, 64'h8000_0001, 64'h0, 64'h0, 0, 0, "illegal_over_misalign");
    do_txn(1'b0, 3'b101, 64'h8000_0002, 64'h0, 64'h8001_1234, 1, 2, "lhu");
  endtask

  task automatic test_timeout(input bit race);
    string tag;
    tag = race ? "timeout_race" : "timeout";
    use64 = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 64'h1000; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (d_resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL %s early: wait cycle %0d got rv=%b required 0", tag, i, d_resp_valid);
      end
    end
    if (race) begin
      mem_rvalid = 1'b1; mem_rdata = 64'h1122_3344;
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    n_checks++;
    if (d_resp_valid !== 1'b1 || d_resp_cause !== (race ? 2'b00 : 2'b10) ||
        d_resp_rdata !== (race ? 32'h1122_3344 : 32'h0)) begin
      n_fail++;
      $display("FAIL %s resp: got rv=%b cause=%b rd=%h", tag, d_resp_valid, d_resp_cause, d_resp_rdata);
    end
    if (!race) begin
      // A late memory response must not disturb the timeout response.
      mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      n_checks++;
      if (d_resp_valid !== 1'b1 || d_resp_cause !== 2'b10 || d_resp_rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL late_rvalid: got rv=%b cause=%b rd=%h required 1 10 0",
                 d_resp_valid, d_resp_cause, d_resp_rdata);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'hCAFE_F00D;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    n_checks++;
    if (d_req_ready !== 1'b1 || d_resp_valid !== 1'b0 || d_mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after: got rr=%b rv=%b mv=%b required 1 0 0",
               tag, d_req_ready, d_resp_valid, d_mem_valid);
    end
    $display("txn %s done", tag);
  endtask

  task automatic test_reset_mid();
    use64 = 1'b0;
    do_txn(1'b0, 3'b010, 64'h0000_3000, 64'h0, 64'h1234_5678, 0, 0, "pre_reset");
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 64'h2000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (d_req_ready !== 1'b0 || d_resp_valid !== 1'b0 || d_mem_valid !== 1'b0 ||
        d_mem_we !== 1'b0 || d_mem_wmask !== 4'b0 || d_resp_rdata !== 32'b0 ||
        d_resp_cause !== 2'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got rr=%b rv=%b mv=%b we=%b m=%b rd=%h c=%b required all 0",
               d_req_ready, d_resp_valid, d_mem_valid, d_mem_we, d_mem_wmask, d_resp_rdata,
               d_resp_cause);
    end
    mem_rvalid = 1'b1; mem_rdata = 64'h5555_AAAA;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (d_resp_valid !== 1'b0 || d_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_after: got rv=%b rr=%b required rv=0 rr=1", d_resp_valid, d_req_ready);
    end
    do_txn(1'b0, 3'b100, 64'h0000_2001, 64'h0, 64'h0000_9900, 0, 1, "post_reset_lbu");
  endtask

  task automatic test_back_to_back();
    use64 = 1'b0;
    do_txn(1'b1, 3'b000, 64'h10, 64'h0000_00A5, 64'h0, 0, 0, "b2b_sb");
    do_txn(1'b0, 3'b000, 64'h13, 64'h0, 64'h7F00_0000, 0, 0, "b2b_lb");
    do_txn(1'b0, 3'b001, 64'h12, 64'h0, 64'h8000_0000, 0, 0, "b2b_lh");
  endtask

  task automatic test_random(input bit wide, input int n);
    bit          we;
    logic [2:0]  f3;
    logic [63:0] addr;
    use64 = wide;
    for (int t = 0; t < n; t++) begin
      we   = 1'($urandom);
      f3   = 3'($urandom);
      addr = {$urandom, $urandom};
      if (!wide) addr[63:32] = '0;
      if ($urandom_range(3) != 0) addr = addr & ~64'((1 << f3[1:0]) - 1);
      do_txn(we, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(2), $urandom_range(2), wide ? "rand64" : "rand32");
    end
  endtask

  task automatic test_x64();
    use64 = 1'b1;
    do_txn(1'b0, 3'b110, 64'h0000_0000_8000_0004, 64'h0, 64'hF000_0000_0000_0000, 0, 0, "lwu64");
    do_txn(1'b0, 3'b010, 64'h0000_0000_8000_0004, 64'h0, 64'hF000_0000_0000_0000, 0, 0, "lw64");
    do_txn(1'b1, 3'b011, 64'h0000_0000_8000_0008, 64'h0123_4567_89AB_CDEF, 64'h0, 1, 1, "sd64");
    do_txn(1'b0, 3'b011, 64'h0000_0000_8000_0004, 64'h0, 64'h0, 0, 0, "ld64_misaligned");
    do_txn(1'b1, 3'b110, 64'h0000_0000_8000_0004, 64'h0, 64'h0, 0, 0, "store_f3_110");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_back_to_back();
    test_reset_mid();
    test_random(1'b0, 40);
    test_x64();
    test_random(1'b1, 25);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
